// File: rtl/qcv_ex_block.sv
// rtl/qcv_ex_block.sv - qcv execute stage with ALU, branch resolution and WB output register
//
// qcv_alu: 32-bit integer ALU.
//   operator_i          4-bit operator {funct7[5], funct3}-style encoding
//   operand_a_i/b_i     32-bit operands
//   result_o            arithmetic/logic result
//   comparison_result_o a < b (unsigned for SLTU, signed otherwise)
//   is_equal_result_o   a == b
//
// qcv_ex_block: accepts one operation per ID handshake and holds it in a
// single-entry output stage toward WB.
//   clk_i, rst_i (sync, active-high), flush_i
//   id_valid_i/id_ready_o    ID handshake
//   alu_operator_i, operand_a_i, operand_b_i, branch_i, branch_type_i,
//   pc_i, imm_i, rd_addr_i, rd_we_i
//   ex_valid_o/wb_ready_i    WB handshake
//   result_o, rd_addr_o, rd_we_o, branch_taken_o, branch_target_o

module qcv_alu (
  input  logic [3:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o,
  output logic        comparison_result_o,
  output logic        is_equal_result_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed           = $signed(operand_a_i) < $signed(operand_b_i);
  assign lt_unsigned         = operand_a_i < operand_b_i;
  assign comparison_result_o = (operator_i == OP_SLTU) ? lt_unsigned : lt_signed;
  assign is_equal_result_o   = operand_a_i == operand_b_i;

  always_comb begin
    result_o = 32'd0;
    case (operator_i)
      OP_ADD:  result_o = operand_a_i + operand_b_i;
      OP_SUB:  result_o = operand_a_i - operand_b_i;
      OP_SLL:  result_o = operand_a_i << operand_b_i[4:0];
      OP_SRL:  result_o = operand_a_i >> operand_b_i[4:0];
      OP_SRA:  result_o = $unsigned($signed(operand_a_i) >>> operand_b_i[4:0]);
      OP_SLT:  result_o = {31'd0, lt_signed};
      OP_SLTU: result_o = {31'd0, lt_unsigned};
      OP_XOR:  result_o = operand_a_i ^ operand_b_i;
      OP_OR:   result_o = operand_a_i | operand_b_i;
      OP_AND:  result_o = operand_a_i & operand_b_i;
      default: result_o = 32'd0;
    endcase
  end

endmodule

module qcv_ex_block (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [3:0]  alu_operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        branch_i,
  input  logic [2:0]  branch_type_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_we_i,
  output logic        ex_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o
);

  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_cmp;
  logic        alu_eq;
  logic        taken_d;
  logic [31:0] target_d;
  logic        capture;

  qcv_alu u_alu (
    .operator_i          (alu_op),
    .operand_a_i         (operand_a_i),
    .operand_b_i         (operand_b_i),
    .result_o            (alu_result),
    .comparison_result_o (alu_cmp),
    .is_equal_result_o   (alu_eq)
  );

  // Branches steer the ALU towards the compare flavour their funct3 needs;
  // funct3[0] inverts the sense (BNE/BGE/BGEU).
  always_comb begin
    alu_op  = alu_operator_i;
    taken_d = 1'b0;
    if (branch_i) begin
      case (branch_type_i)
        3'b000: begin alu_op = 4'b1000; taken_d = alu_eq;   end
        3'b001: begin alu_op = 4'b1000; taken_d = !alu_eq;  end
        3'b100: begin alu_op = 4'b0010; taken_d = alu_cmp;  end
        3'b101: begin alu_op = 4'b0010; taken_d = !alu_cmp; end
        3'b110: begin alu_op = 4'b0011; taken_d = alu_cmp;  end
        3'b111: begin alu_op = 4'b0011; taken_d = !alu_cmp; end
        default: begin alu_op = 4'b0000; taken_d = 1'b0;    end
      endcase
    end
  end

  // Dedicated target adder so the ALU stays free for the compare.
  assign target_d = pc_i + imm_i;

  assign id_ready_o = !ex_valid_o || wb_ready_i;
  assign capture    = id_valid_i && id_ready_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o      <= 1'b0;
      result_o        <= 32'd0;
      rd_addr_o       <= 5'd0;
      rd_we_o         <= 1'b0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= 32'd0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (capture) begin
      ex_valid_o      <= 1'b1;
      result_o        <= branch_i ? 32'd0 : alu_result;
      rd_addr_o       <= rd_addr_i;
      rd_we_o         <= rd_we_i && !branch_i;
      branch_taken_o  <= branch_i && taken_d;
      branch_target_o <= target_d;
    end else if (wb_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qcv_ex_block.sv
// tb/tb_qcv_ex_block.sv - randomized self-checking bench for qcv_ex_block

module tb_qcv_ex_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [3:0]  alu_operator = 4'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        branch = 1'b0;
  logic [2:0]  branch_type = 3'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] imm = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        rd_we = 1'b0;
  logic        ex_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_addr_q;
  logic        rd_we_q;
  logic        branch_taken;
  logic [31:0] branch_target;

  int checks = 0;
  int errors = 0;

  // Reference state: what WB should currently see.
  logic        m_valid = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_we = 1'b0;
  logic        m_taken = 1'b0;
  logic [31:0] m_target = 32'd0;

  always #5 clk = ~clk;

  qcv_ex_block dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .id_valid_i      (id_valid),
    .id_ready_o      (id_ready),
    .alu_operator_i  (alu_operator),
    .operand_a_i     (operand_a),
    .operand_b_i     (operand_b),
    .branch_i        (branch),
    .branch_type_i   (branch_type),
    .pc_i            (pc),
    .imm_i           (imm),
    .rd_addr_i       (rd_addr),
    .rd_we_i         (rd_we),
    .ex_valid_o      (ex_valid),
    .wb_ready_i      (wb_ready),
    .result_o        (result),
    .rd_addr_o       (rd_addr_q),
    .rd_we_o         (rd_we_q),
    .branch_taken_o  (branch_taken),
    .branch_target_o (branch_target)
  );

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic taken_ref(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic [2:0] bt, input logic [31:0] p,
                        input logic [31:0] im, input logic [4:0] rd, input logic we);
    alu_operator = op; operand_a = a; operand_b = b; branch = br; branch_type = bt;
    pc = p; imm = im; rd_addr = rd; rd_we = we;
  endtask

  // One clock: check ready, advance the reference at the edge, then check outputs.
  task automatic step;
    logic accept;
    #1 check_eq("id_ready", 32'(id_ready), 32'(!m_valid || wb_ready));
    @(posedge clk);
    accept = id_valid && (!m_valid || wb_ready) && !flush;
    if (rst) begin
      m_valid = 1'b0; m_result = 32'd0; m_rd = 5'd0; m_we = 1'b0; m_taken = 1'b0; m_target = 32'd0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (accept) begin
      m_valid  = 1'b1;
      m_result = branch ? 32'd0 : alu_ref(alu_operator, operand_a, operand_b);
      m_rd     = rd_addr;
      m_we     = branch ? 1'b0 : rd_we;
      m_taken  = branch ? taken_ref(branch_type, operand_a, operand_b) : 1'b0;
      m_target = pc + imm;
    end else if (wb_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("ex_valid", 32'(ex_valid), 32'(m_valid));
    check_eq("result", result, m_result);
    check_eq("rd_addr", 32'(rd_addr_q), 32'(m_rd));
    check_eq("rd_we", 32'(rd_we_q), 32'(m_we));
    check_eq("taken", 32'(branch_taken), 32'(m_taken));
    check_eq("target", branch_target, m_target);
  endtask

  initial begin
    step(); step();
    check_eq("reset_valid", 32'(ex_valid), 32'd0);
    check_eq("reset_result", result, 32'd0);
    rst = 1'b0;

    // ADD overflow into sign bit
    wb_ready = 1'b1; id_valid = 1'b1;
    set_op(4'b0000, 32'h7FFFFFFF, 32'd1, 1'b0, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1);
    step();
    check_eq("add_result", result, 32'h80000000);
    check_eq("add_rd", 32'(rd_addr_q), 32'd5);

    // Back-pressure: SUB held while XOR waits, then zero-bubble capture
    set_op(4'b1000, 32'd10, 32'd3, 1'b0, 3'd0, 32'h0, 32'h0, 5'd6, 1'b1);
    step();
    set_op(4'b0100, 32'hF0, 32'h0F, 1'b0, 3'd0, 32'h0, 32'h0, 5'd7, 1'b1);
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_result", result, 32'd7);
      check_eq("stall_ready", 32'(id_ready), 32'd0);
    end
    wb_ready = 1'b1;
    step();
    check_eq("xor_result", result, 32'hFF);
    check_eq("xor_valid", 32'(ex_valid), 32'd1);

    // Signed / unsigned branches
    set_op(4'b0110, 32'hFFFFFFFF, 32'd1, 1'b1, 3'b100, 32'h100, 32'hFFFFFFF0, 5'd1, 1'b1);
    step();
    check_eq("blt_taken", 32'(branch_taken), 32'd1);
    check_eq("blt_target", branch_target, 32'h000000F0);
    set_op(4'b0110, 32'hFFFFFFFF, 32'd1, 1'b1, 3'b110, 32'h100, 32'hFFFFFFF0, 5'd1, 1'b1);
    step();
    check_eq("bltu_taken", 32'(branch_taken), 32'd0);
    set_op(4'b0110, 32'd5, 32'd5, 1'b1, 3'b101, 32'h100, 32'hFFFFFFF0, 5'd1, 1'b1);
    step();
    check_eq("bge_taken", 32'(branch_taken), 32'd1);
    check_eq("bge_we", 32'(rd_we_q), 32'd0);

    // Equality and reserved branches, target wrap
    set_op(4'b0000, 32'h1234, 32'h1234, 1'b1, 3'b000, 32'hFFFFFFFC, 32'd8, 5'd2, 1'b1);
    step();
    check_eq("beq_taken", 32'(branch_taken), 32'd1);
    check_eq("wrap_target", branch_target, 32'h00000004);
    set_op(4'b0000, 32'h1234, 32'h1234, 1'b1, 3'b001, 32'h0, 32'h0, 5'd2, 1'b1);
    step();
    check_eq("bne_taken", 32'(branch_taken), 32'd0);
    set_op(4'b0000, 32'h1234, 32'h1234, 1'b1, 3'b010, 32'h0, 32'h0, 5'd2, 1'b1);
    step();
    check_eq("rsvd_taken", 32'(branch_taken), 32'd0);

    // Flush beats capture and held entry
    set_op(4'b0000, 32'd1, 32'd2, 1'b0, 3'd0, 32'h0, 32'h0, 5'd3, 1'b1);
    wb_ready = 1'b0;
    step();
    flush = 1'b1;
    set_op(4'b0000, 32'd4, 32'd4, 1'b0, 3'd0, 32'h0, 32'h0, 5'd4, 1'b1);
    step();
    check_eq("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;
    step();
    check_eq("post_flush_result", result, 32'd8);

    // Reset mid-stall
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; id_valid = 1'b0;
    check_eq("rst_stall_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_stall_result", result, 32'd0);
    #1 check_eq("rst_stall_ready", 32'(id_ready), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a = {29'd0, 3'($urandom_range(0, 7))};
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 2) == 0) b = {29'd0, 3'($urandom_range(0, 7))};
      set_op(4'($urandom), a, b, ($urandom_range(0, 2) == 0), 3'($urandom),
             $urandom, $urandom, 5'($urandom), 1'($urandom));
      id_valid = ($urandom_range(0, 3) != 0);
      wb_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qcv_ex_block.md
Name: qcv_ex_block

Overview:
Execute stage of the qcv core. Accepts one decoded operation per handshake from ID, instantiates qcv_alu and drives its operator and operands. Resolves conditional branches from the ALU compare and equal outputs, and computes the branch target on a dedicated adder. Registers the result into a single-entry output stage with a valid/ready handshake toward WB.

Parameters:
None. The datapath is fixed at 32 bits to match qcv_alu.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  kill the held output entry and any same-cycle capture
id_valid_i  input  1  ID presents a valid operation
id_ready_o  output  1  EX can accept this cycle
alu_operator_i  input  4  qcv_alu operator encoding; ignored when branch_i=1
operand_a_i  input  32  operand A (rs1 or PC)
operand_b_i  input  32  operand B (rs2 or immediate)
branch_i  input  1  operation is a conditional branch
branch_type_i  input  3  RV32I branch funct3
pc_i  input  32  PC of the operation
imm_i  input  32  sign-extended branch offset
rd_addr_i  input  5  destination register
rd_we_i  input  1  destination write enable
ex_valid_o  output  1  output entry valid
wb_ready_i  input  1  WB accepts the entry
result_o  output  32  registered ALU result
rd_addr_o  output  5  registered rd
rd_we_o  output  1  registered write enable; forced 0 for branches
branch_taken_o  output  1  registered taken decision; meaningful only with ex_valid_o
branch_target_o  output  32  registered pc_i+imm_i (mod 2^32)

Behaviour:
- Reset: when rst_i=1 at a clock edge, all registered outputs go to 0 (ex_valid_o, result_o, rd_addr_o, rd_we_o, branch_taken_o, branch_target_o). rst_i overrides flush and capture; an in-flight entry is dropped.
- Ready: id_ready_o = !ex_valid_o || wb_ready_i. This is combinational and has no dependence on id_valid_i.
- Capture: fires when id_valid_i && id_ready_o && !flush_i. The output registers load on the next edge, giving one-cycle latency from accept to ex_valid_o.
- Output update on an edge, in priority order:
  1. rst_i: clear everything.
  2. flush_i: ex_valid_o goes to 0; data registers hold.
  3. Capture: load all registers and set ex_valid_o=1.
  4. wb_ready_i && ex_valid_o with no capture: ex_valid_o goes to 0.
  5. Otherwise hold.
- Stall: while ex_valid_o=1 and wb_ready_i=0, every output is held bit-stable.
- Back-to-back: a WB handshake and a new capture in the same cycle sustain one operation per cycle with no bubble.
- ALU operator selection for non-branches: alu_operator_i is passed straight through. result_o = ALU result_o. rd_we_o = rd_we_i. branch_taken_o = 0.
- ALU operator selection for branches (branch_i=1):
  - BEQ 000: drive SUB 1000; taken = is_equal.
  - BNE 001: drive SUB 1000; taken = !is_equal.
  - BLT 100: drive SLT 0010; taken = comparison result.
  - BGE 101: drive SLT 0010; taken = !comparison result.
  - BLTU 110: drive SLTU 0011; taken = comparison result.
  - BGEU 111: drive SLTU 0011; taken = !comparison result.
  - Reserved 010/011: drive ADD; taken = 0.
- Branch outputs: for any branch, rd_we_o = 0 and result_o = 0.
- Branch target: branch_target_o = pc_i + imm_i, computed on a separate adder and registered for every operation (don't-care when not a branch). Carry is discarded; 0xFFFFFFFC + 8 gives 0x00000004.
- ALU inputs are driven combinationally from the ID inputs. Nothing is read from the ALU when no capture occurs.
- No internal flush generation: the consumer of branch_taken_o flushes ID and EX.

Test Plan:
- Reset mid-stall: entry valid with wb_ready_i=0, then assert rst_i for one cycle -> next cycle ex_valid_o=0, result_o=0, id_ready_o=1.
- ADD: op 0000, A=0x7FFFFFFF, B=1, rd=5, we=1, wb_ready_i=1 -> one cycle later ex_valid_o=1, result_o=0x80000000, rd_addr_o=5, rd_we_o=1, branch_taken_o=0.
- Back-pressure: issue SUB 10-3, hold wb_ready_i=0 for 3 cycles while ID offers XOR.
  - During stall: id_ready_o=0, result_o stays 7, no capture.
  - On the wb_ready_i=1 cycle: XOR is captured the same cycle (zero bubble).
- Signed branches:
  - BLT with A=0xFFFFFFFF, B=1 -> taken=1.
  - BLTU with the same operands -> taken=0.
  - BGE with A=B=5 -> taken=1.
  - All three: rd_we_o=0; branch_target_o = pc 0x100 + imm 0xFFFFFFF0 = 0x000000F0.
- Equality branches:
  - BEQ with A=B=0x1234 -> taken=1.
  - BNE with the same operands -> taken=0.
  - Reserved funct3 010 -> taken=0.
- Flush priority: flush_i=1 in the same cycle as a valid capture and a held entry -> next cycle ex_valid_o=0; the following cycle accepts normally.
